// File: rtl/mips_load_store_unit_if.sv
// Memory bus between the load/store unit and the byte-enabled data RAM.
// Latency: none (wires only); read data returns the cycle after a read is accepted.
// Backpressure: mem_waitrequest high stalls the master, which holds every request field.
// Ports: master drives address/strobes/byteenable/writedata; slave drives readdata/waitrequest.
interface mips_load_store_unit_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    modport master (
        output mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
        input  mem_readdata, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, mem_write, mem_byteenable, mem_writedata,
        output mem_readdata, mem_waitrequest
    );
endinterface

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: one word-aligned RAM transaction per access, with lane enables,
// lane-replicated store data and extend/merge of load data; misaligned/unknown ops rejected.
// Latency: store done in cycle 2, load in cycle 3, reject in cycle 1; +1 per waitrequest cycle.
// Ports: clk, reset (sync, active-high), start/op/addr/rt_val request, busy/done/result/err
// response, bus = memory master. start is ignored while busy; no queueing.
module mips_load_store_unit (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [3:0]                    op,
    input  logic [31:0]                   addr,
    input  logic [31:0]                   rt_val,
    output logic                          busy,
    output logic                          done,
    output logic [31:0]                   result,
    output logic                          err,
    mips_load_store_unit_if.master        bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_REQ    = 2'd1,
        S_RDWAIT = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] rt_q;
    logic        err_q;
    logic [31:0] result_q;

    logic        req_legal;
    logic        req_aligned;
    logic [1:0]  o;
    logic [3:0]  be_c;
    logic [31:0] wd_c;
    logic [31:0] load_val;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    // Decode of the incoming request (only meaningful while sampling start in IDLE).
    always_comb begin
        req_legal   = 1'b0;
        req_aligned = 1'b1;
        case (op)
            4'b0000, 4'b0010, 4'b0100, 4'b0110,
            4'b1000, 4'b1010, 4'b1110:          req_legal = 1'b1;
            4'b0001, 4'b0101, 4'b1001: begin
                req_legal   = 1'b1;
                req_aligned = ~addr[0];
            end
            4'b0011, 4'b1011: begin
                req_legal   = 1'b1;
                req_aligned = (addr[1:0] == 2'b00);
            end
            default:                            req_legal = 1'b0;
        endcase
    end

    assign o = addr_q[1:0];

    // Lane enables and write data for the latched op. Loads use only be_c.
    always_comb begin
        be_c = 4'b0000;
        wd_c = 32'h0;
        case (op_q[2:0])
            3'b000, 3'b100: begin                    // LB/LBU/SB
                be_c = 4'b0001 << o;
                wd_c = {4{rt_q[7:0]}};
            end
            3'b001, 3'b101: begin                    // LH/LHU/SH
                be_c = o[1] ? 4'b1100 : 4'b0011;
                wd_c = {2{rt_q[15:0]}};
            end
            3'b011: begin                            // LW/SW
                be_c = 4'b1111;
                wd_c = rt_q;
            end
            3'b010: begin                            // LWL/SWL
                if (op_q[3]) begin
                    case (o)
                        2'd0: begin be_c = 4'b0001; wd_c = {24'h0, rt_q[31:24]}; end
                        2'd1: begin be_c = 4'b0011; wd_c = {16'h0, rt_q[31:16]}; end
                        2'd2: begin be_c = 4'b0111; wd_c = {8'h0,  rt_q[31:8]};  end
                        default: begin be_c = 4'b1111; wd_c = rt_q; end
                    endcase
                end else begin
                    be_c = 4'b1111;
                end
            end
            3'b110: begin                            // LWR/SWR
                if (op_q[3]) begin
                    case (o)
                        2'd0: begin be_c = 4'b1111; wd_c = rt_q; end
                        2'd1: begin be_c = 4'b1110; wd_c = {rt_q[23:0], 8'h0};  end
                        2'd2: begin be_c = 4'b1100; wd_c = {rt_q[15:0], 16'h0}; end
                        default: begin be_c = 4'b1000; wd_c = {rt_q[7:0], 24'h0}; end
                    endcase
                end else begin
                    be_c = 4'b1111;
                end
            end
            default: begin
                be_c = 4'b0000;
                wd_c = 32'h0;
            end
        endcase
    end

    // Load extraction / extension / unaligned merge from the returned word.
    always_comb begin
        case (o)
            2'd0:    rd_byte = bus.mem_readdata[7:0];
            2'd1:    rd_byte = bus.mem_readdata[15:8];
            2'd2:    rd_byte = bus.mem_readdata[23:16];
            default: rd_byte = bus.mem_readdata[31:24];
        endcase
        rd_half  = o[1] ? bus.mem_readdata[31:16] : bus.mem_readdata[15:0];
        load_val = bus.mem_readdata;
        case (op_q[2:0])
            3'b000: load_val = {{24{rd_byte[7]}}, rd_byte};
            3'b100: load_val = {24'h0, rd_byte};
            3'b001: load_val = {{16{rd_half[15]}}, rd_half};
            3'b101: load_val = {16'h0, rd_half};
            3'b010: begin
                case (o)
                    2'd0:    load_val = {bus.mem_readdata[7:0],  rt_q[23:0]};
                    2'd1:    load_val = {bus.mem_readdata[15:0], rt_q[15:0]};
                    2'd2:    load_val = {bus.mem_readdata[23:0], rt_q[7:0]};
                    default: load_val = bus.mem_readdata;
                endcase
            end
            3'b110: begin
                case (o)
                    2'd0:    load_val = bus.mem_readdata;
                    2'd1:    load_val = {rt_q[31:24], bus.mem_readdata[31:8]};
                    2'd2:    load_val = {rt_q[31:16], bus.mem_readdata[31:16]};
                    default: load_val = {rt_q[31:8],  bus.mem_readdata[31:24]};
                endcase
            end
            default: load_val = bus.mem_readdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = (req_legal && req_aligned) ? S_REQ : S_DONE;
                end
            end
            S_REQ: begin
                if (!bus.mem_waitrequest) begin
                    state_d = op_q[3] ? S_DONE : S_RDWAIT;
                end
            end
            S_RDWAIT: state_d = S_DONE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            op_q     <= 4'h0;
            addr_q   <= 32'h0;
            rt_q     <= 32'h0;
            err_q    <= 1'b0;
            result_q <= 32'h0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                op_q   <= op;
                addr_q <= addr;
                rt_q   <= rt_val;
                err_q  <= ~(req_legal && req_aligned);
            end
            // Rejected accesses never pass through RDWAIT, so result is left untouched.
            if (state_q == S_RDWAIT) begin
                result_q <= load_val;
            end
        end
    end

    // Bus fields are driven only in REQ; they derive from latched state, so they hold
    // steady for as long as waitrequest stalls the transaction.
    assign bus.mem_read       = (state_q == S_REQ) && !op_q[3];
    assign bus.mem_write      = (state_q == S_REQ) &&  op_q[3];
    assign bus.mem_address    = (state_q == S_REQ) ? {addr_q[31:2], 2'b00} : 32'h0;
    assign bus.mem_byteenable = (state_q == S_REQ) ? be_c : 4'b0000;
    assign bus.mem_writedata  = bus.mem_write ? wd_c : 32'h0;

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign err    = done && err_q;
    assign result = result_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Directed bench for mips_load_store_unit with a byte-enabled word RAM model.
// Latency: RAM returns read data the cycle after an accepted read.
// Backpressure: bench raises mem_waitrequest for a chosen number of strobe cycles.
module tb_mips_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] rt_val;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        err;

    always #5 clk = ~clk;

    mips_load_store_unit_if bus ();

    mips_load_store_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .addr   (addr),
        .rt_val (rt_val),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err),
        .bus    (bus)
    );

    logic [31:0] ram [0:255];

    always @(posedge clk) begin
        if (bus.mem_read && !bus.mem_waitrequest)
            bus.mem_readdata <= ram[bus.mem_address[9:2]];
        if (bus.mem_write && !bus.mem_waitrequest)
            for (int k = 0; k < 4; k++)
                if (bus.mem_byteenable[k])
                    ram[bus.mem_address[9:2]][8*k +: 8] <= bus.mem_writedata[8*k +: 8];
    end

    int checks = 0;
    int errors = 0;

    // Per-access observations.
    int          done_cyc;
    int          strobes;
    logic [31:0] res_o;
    logic        err_o;
    logic [31:0] s_addr;
    logic [3:0]  s_be;
    logic [31:0] s_wd;
    logic        stable;
    logic        busy_after;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one access; start is sampled at edge 0 and cycle n is the cycle after edge n-1.
    task automatic do_op(input logic [3:0] o_in, input logic [31:0] a_in,
                         input logic [31:0] r_in, input int wt);
        op = o_in; addr = a_in; rt_val = r_in; start = 1'b1;
        bus.mem_waitrequest = (wt > 0);
        done_cyc = 0; strobes = 0; stable = 1'b1;
        res_o = 32'h0; err_o = 1'b0;
        s_addr = 32'h0; s_be = 4'h0; s_wd = 32'h0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 20 && done_cyc == 0; cyc++) begin
            if (bus.mem_read || bus.mem_write) begin
                strobes++;
                if (strobes == 1) begin
                    s_addr = bus.mem_address; s_be = bus.mem_byteenable; s_wd = bus.mem_writedata;
                end else if (s_addr !== bus.mem_address || s_be !== bus.mem_byteenable ||
                             s_wd !== bus.mem_writedata) begin
                    stable = 1'b0;
                end
                bus.mem_waitrequest = (strobes <= wt);
            end else begin
                bus.mem_waitrequest = 1'b0;
            end
            if (done) begin
                done_cyc = cyc; res_o = result; err_o = err;
            end else begin
                @(posedge clk); #1;
            end
        end
        bus.mem_waitrequest = 1'b0;
        @(posedge clk); #1;
        busy_after = busy;
    endtask

    task automatic load_chk(input string tag, input logic [3:0] o_in, input logic [31:0] a_in,
                            input logic [31:0] r_in, input logic [31:0] exp);
        do_op(o_in, a_in, r_in, 0);
        check({tag, "_cyc"}, 32'(done_cyc), 32'd3);
        check({tag, "_err"}, {31'h0, err_o}, 32'h0);
        check({tag, "_res"}, res_o, exp);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        ram[64] = 32'h8899AABB;
        bus.mem_readdata = 32'h0;
        bus.mem_waitrequest = 1'b0;
        reset = 1'b1; start = 1'b0; op = 4'h0; addr = 32'h0; rt_val = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  {31'h0, busy}, 32'h0);
        check("rst_done",  {31'h0, done}, 32'h0);
        check("rst_err",   {31'h0, err}, 32'h0);
        check("rst_res",   result, 32'h0);
        check("rst_strobe", {30'h0, bus.mem_read, bus.mem_write}, 32'h0);
        check("rst_addr",  bus.mem_address, 32'h0);
        check("rst_be",    {28'h0, bus.mem_byteenable}, 32'h0);
        check("rst_wd",    bus.mem_writedata, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        load_chk("lb",  4'b0000, 32'h103, 32'h0, 32'hFFFFFF88);
        check("lb_be", {28'h0, s_be}, 32'h8);
        check("lb_addr", s_addr, 32'h100);
        check("lb_busy_after", {31'h0, busy_after}, 32'h0);
        load_chk("lbu", 4'b0100, 32'h101, 32'h0, 32'h000000AA);
        check("lbu_be", {28'h0, s_be}, 32'h2);
        load_chk("lh",  4'b0001, 32'h100, 32'h0, 32'hFFFFAABB);
        check("lh_be", {28'h0, s_be}, 32'h3);
        load_chk("lhu", 4'b0101, 32'h102, 32'h0, 32'h00008899);
        check("lhu_be", {28'h0, s_be}, 32'hC);
        load_chk("lwl", 4'b0010, 32'h101, 32'h11223344, 32'hAABB3344);
        load_chk("lwr", 4'b0110, 32'h102, 32'h11223344, 32'h11228899);

        do_op(4'b1000, 32'h103, 32'h000000CD, 2);
        check("sb_cyc",    32'(done_cyc), 32'd4);
        check("sb_err",    {31'h0, err_o}, 32'h0);
        check("sb_strobes", 32'(strobes), 32'd3);
        check("sb_addr",   s_addr, 32'h100);
        check("sb_be",     {28'h0, s_be}, 32'h8);
        check("sb_wd",     s_wd, 32'hCDCDCDCD);
        check("sb_stable", {31'h0, stable}, 32'h1);
        load_chk("lw_after_sb", 4'b0011, 32'h100, 32'h0, 32'hCD99AABB);

        do_op(4'b1010, 32'h102, 32'h11223344, 0);
        check("swl_cyc", 32'(done_cyc), 32'd2);
        check("swl_be",  {28'h0, s_be}, 32'h7);
        check("swl_wd",  s_wd, 32'h00112233);
        do_op(4'b1110, 32'h101, 32'h11223344, 0);
        check("swr_cyc", 32'(done_cyc), 32'd2);
        check("swr_be",  {28'h0, s_be}, 32'hE);
        check("swr_wd",  s_wd, 32'h22334400);
        load_chk("lw_after_swlr", 4'b0011, 32'h100, 32'h0, 32'h22334433);

        do_op(4'b0011, 32'h102, 32'h0, 0);
        check("lwmis_cyc", 32'(done_cyc), 32'd1);
        check("lwmis_err", {31'h0, err_o}, 32'h1);
        check("lwmis_strobes", 32'(strobes), 32'd0);
        check("lwmis_res", res_o, 32'h22334433);
        do_op(4'b0111, 32'h100, 32'h0, 0);
        check("badop_cyc", 32'(done_cyc), 32'd1);
        check("badop_err", {31'h0, err_o}, 32'h1);
        check("badop_strobes", 32'(strobes), 32'd0);
        check("badop_res", res_o, 32'h22334433);

        // Reset in cycle 2 of a load stalled by waitrequest.
        op = 4'b0011; addr = 32'h100; rt_val = 32'h0; start = 1'b1;
        bus.mem_waitrequest = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("rstmid_c1_read", {31'h0, bus.mem_read}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_waitrequest = 1'b0;
        check("rstmid_read", {31'h0, bus.mem_read}, 32'h0);
        check("rstmid_outs", {28'h0, busy, done, err, bus.mem_write}, 32'h0);
        check("rstmid_res",  result, 32'h0);
        check("rstmid_be",   {28'h0, bus.mem_byteenable}, 32'h0);
        check("rstmid_addr", bus.mem_address, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("rstmid_nodone", {31'h0, done}, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
